mul_issue_ctrl: RTL and testbench

- Controller/scheduler for the fixed-latency, non-stalling STAGES-deep pipelined multiplier datapath.
- Accepts decoded multiply ops from the MUL reservation station and converts operands to 2*XLEN magnitudes for the datapath.
- Carries each op's tag (func, sign-fix, prf/rob idx) in a shift register that runs alongside the pipe.
- Applies the final sign correction and result select, queues finished results in an output FIFO until the CDB grants them, and uses credits so no result is ever dropped.

---
 rtl/mul_issue_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_mul_issue_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mul_issue_ctrl
// Brief   : Issue/completion controller for a fixed-latency pipelined
//           multiplier: operand magnitudes, tag pipe, sign fix, credited FIFO.
//           Optional squash port enabled by defining MUL_SQUASH_EN.
// Revision: 1.0 - initial release
// ============================================================================
module mul_issue_ctrl #(
    parameter int XLEN      = 32,
    parameter int STAGES    = 8,
    parameter int PRF_LEN   = 6,
    parameter int ROB_LEN   = 5,
    parameter int OUT_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
`ifdef MUL_SQUASH_EN
    input  logic                 squash,
`endif
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [1:0]           issue_func,
    input  logic [XLEN-1:0]      issue_opa,
    input  logic [XLEN-1:0]      issue_opb,
    input  logic [PRF_LEN-1:0]   issue_prf_idx,
    input  logic [ROB_LEN-1:0]   issue_rob_idx,
    output logic                 mul_start,
    output logic [2*XLEN-1:0]    mul_mcand,
    output logic [2*XLEN-1:0]    mul_mplier,
    input  logic                 mul_done,
    input  logic [2*XLEN-1:0]    mul_product,
    output logic                 cdb_valid,
    output logic [XLEN-1:0]      cdb_value,
    output logic [PRF_LEN-1:0]   cdb_prf_idx,
    output logic [ROB_LEN-1:0]   cdb_rob_idx,
    input  logic                 cdb_grant,
    output logic                 err_desync
);

    localparam logic [1:0] c_func_mul  = 2'd0;
    localparam logic [1:0] c_func_mulh = 2'd1;
    localparam logic [1:0] c_func_mulhu = 2'd3;
    localparam int c_ptr_w = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(OUT_DEPTH + 1);
    localparam int c_sum_w = $clog2(STAGES + OUT_DEPTH + 1);

    logic                 w_squash;
    logic                 w_fire;
    logic                 w_a_signed;
    logic                 w_b_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [XLEN-1:0]      w_a_mag;
    logic [XLEN-1:0]      w_b_mag;
    logic [c_sum_w-1:0]   w_inflight;
    logic                 w_credit_ok;
    logic                 w_exit_valid;
    logic                 w_exit_sq;
    logic                 w_push;
    logic                 w_pop;
    logic [2*XLEN-1:0]    w_full;
    logic [XLEN-1:0]      w_result;

    logic [STAGES-1:0]    r_tag_valid;
    logic [1:0]           r_tag_func [STAGES];
    logic                 r_tag_neg  [STAGES];
    logic [PRF_LEN-1:0]   r_tag_prf  [STAGES];
    logic [ROB_LEN-1:0]   r_tag_rob  [STAGES];

    logic [XLEN-1:0]      r_fifo_value [OUT_DEPTH];
    logic [PRF_LEN-1:0]   r_fifo_prf   [OUT_DEPTH];
    logic [ROB_LEN-1:0]   r_fifo_rob   [OUT_DEPTH];
    logic [c_ptr_w-1:0]   r_head;
    logic [c_ptr_w-1:0]   r_tail;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_err_desync;

`ifdef MUL_SQUASH_EN
    // Marks pipe slots whose op was squashed; their datapath done is expected.
    logic [STAGES-1:0]    r_tag_sq;

    assign w_squash  = squash;
    assign w_exit_sq = r_tag_sq[STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tag_sq <= '0;
        end else if (w_squash) begin
            r_tag_sq <= {r_tag_valid[STAGES-2:0] | r_tag_sq[STAGES-2:0], 1'b0};
        end else begin
            r_tag_sq <= {r_tag_sq[STAGES-2:0], 1'b0};
        end
    end
`else
    assign w_squash  = 1'b0;
    assign w_exit_sq = 1'b0;
`endif

    // Issue side: operand magnitudes and result sign
    assign w_a_signed = (issue_func != c_func_mulhu);
    assign w_b_signed = (issue_func == c_func_mul) || (issue_func == c_func_mulh);
    assign w_a_neg    = w_a_signed & issue_opa[XLEN-1];
    assign w_b_neg    = w_b_signed & issue_opb[XLEN-1];
    assign w_a_mag    = w_a_neg ? -issue_opa : issue_opa;
    assign w_b_mag    = w_b_neg ? -issue_opb : issue_opb;
    assign mul_mcand  = {{XLEN{1'b0}}, w_a_mag};
    assign mul_mplier = {{XLEN{1'b0}}, w_b_mag};

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_inflight = w_inflight + c_sum_w'(r_tag_valid[i]);
        end
    end

    assign w_credit_ok = (w_inflight + c_sum_w'(r_count)) < c_sum_w'(OUT_DEPTH);
    assign issue_ready = reset | (w_credit_ok & ~w_squash);
    assign w_fire      = issue_valid & issue_ready & ~reset;
    assign mul_start   = w_fire;

    // Tag pipe shifts every cycle in lockstep with the datapath
    always_ff @(posedge clock) begin
        if (reset || w_squash) begin
            r_tag_valid <= '0;
        end else begin
            r_tag_valid <= {r_tag_valid[STAGES-2:0], w_fire};
        end
    end

    always_ff @(posedge clock) begin
        r_tag_func[0] <= issue_func;
        r_tag_neg[0]  <= w_a_neg ^ w_b_neg;
        r_tag_prf[0]  <= issue_prf_idx;
        r_tag_rob[0]  <= issue_rob_idx;
        for (int i = 1; i < STAGES; i++) begin
            r_tag_func[i] <= r_tag_func[i-1];
            r_tag_neg[i]  <= r_tag_neg[i-1];
            r_tag_prf[i]  <= r_tag_prf[i-1];
            r_tag_rob[i]  <= r_tag_rob[i-1];
        end
    end

    // Completion: sign correction and high/low half select
    assign w_exit_valid = r_tag_valid[STAGES-1];
    assign w_full       = r_tag_neg[STAGES-1] ? -mul_product : mul_product;
    assign w_result     = (r_tag_func[STAGES-1] == c_func_mul) ? w_full[XLEN-1:0]
                                                               : w_full[2*XLEN-1:XLEN];
    assign w_push       = w_exit_valid & ~w_squash;
    assign w_pop        = cdb_valid & cdb_grant;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_err_desync <= 1'b0;
        end else if ((w_exit_valid != mul_done) && !(w_exit_sq && mul_done)) begin
            r_err_desync <= 1'b1;
        end
    end

    assign err_desync = r_err_desync;

    function automatic logic [c_ptr_w-1:0] ptr_next(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(OUT_DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    // Result FIFO; credits guarantee a push never meets a full queue
    always_ff @(posedge clock) begin
        if (reset || w_squash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= ptr_next(r_tail);
            if (w_pop)  r_head <= ptr_next(r_head);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_value[r_tail] <= w_result;
            r_fifo_prf[r_tail]   <= r_tag_prf[STAGES-1];
            r_fifo_rob[r_tail]   <= r_tag_rob[STAGES-1];
        end
    end

    assign cdb_valid   = (r_count != '0);
    assign cdb_value   = r_fifo_value[r_head];
    assign cdb_prf_idx = r_fifo_prf[r_head];
    assign cdb_rob_idx = r_fifo_rob[r_head];

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_mul_issue_ctrl
// Brief   : Directed scoreboard bench for mul_issue_ctrl with a behavioural
//           fixed-latency multiplier datapath.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mul_issue_ctrl;

    localparam int XLEN      = 32;
    localparam int STAGES    = 8;
    localparam int PRF_LEN   = 6;
    localparam int ROB_LEN   = 5;
    localparam int OUT_DEPTH = 4;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 issue_valid = 1'b0;
    logic                 issue_ready;
    logic [1:0]           issue_func = 2'd0;
    logic [XLEN-1:0]      issue_opa = '0;
    logic [XLEN-1:0]      issue_opb = '0;
    logic [PRF_LEN-1:0]   issue_prf_idx = '0;
    logic [ROB_LEN-1:0]   issue_rob_idx = '0;
    logic                 mul_start;
    logic [2*XLEN-1:0]    mul_mcand;
    logic [2*XLEN-1:0]    mul_mplier;
    logic                 mul_done;
    logic [2*XLEN-1:0]    mul_product;
    logic                 cdb_valid;
    logic [XLEN-1:0]      cdb_value;
    logic [PRF_LEN-1:0]   cdb_prf_idx;
    logic [ROB_LEN-1:0]   cdb_rob_idx;
    logic                 cdb_grant = 1'b1;
    logic                 err_desync;
`ifdef MUL_SQUASH_EN
    logic                 squash = 1'b0;
`endif

    always #5 clock = ~clock;

    mul_issue_ctrl #(
        .XLEN(XLEN), .STAGES(STAGES), .PRF_LEN(PRF_LEN),
        .ROB_LEN(ROB_LEN), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
`ifdef MUL_SQUASH_EN
        .squash(squash),
`endif
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_func(issue_func), .issue_opa(issue_opa), .issue_opb(issue_opb),
        .issue_prf_idx(issue_prf_idx), .issue_rob_idx(issue_rob_idx),
        .mul_start(mul_start), .mul_mcand(mul_mcand), .mul_mplier(mul_mplier),
        .mul_done(mul_done), .mul_product(mul_product),
        .cdb_valid(cdb_valid), .cdb_value(cdb_value),
        .cdb_prf_idx(cdb_prf_idx), .cdb_rob_idx(cdb_rob_idx),
        .cdb_grant(cdb_grant), .err_desync(err_desync)
    );

    // Behavioural datapath: unsigned product, done exactly STAGES cycles after start
    logic [STAGES-1:0]    dp_v;
    logic [2*XLEN-1:0]    dp_p [STAGES];

    always @(posedge clock) begin
        if (reset) begin
            dp_v <= '0;
        end else begin
            dp_v <= {dp_v[STAGES-2:0], mul_start};
        end
        dp_p[0] <= mul_mcand * mul_mplier;
        for (int k = 1; k < STAGES; k++) dp_p[k] <= dp_p[k-1];
    end

    assign mul_done    = dp_v[STAGES-1];
    assign mul_product = dp_p[STAGES-1];

    typedef struct packed {
        logic [XLEN-1:0]    value;
        logic [PRF_LEN-1:0] prf;
        logic [ROB_LEN-1:0] rob;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, p;
        sa = (f != 2'd3) ? {{32{a[31]}}, a} : {32'b0, a};
        sb = (f < 2'd2)  ? {{32{b[31]}}, b} : {32'b0, b};
        p  = sa * sb;
        return (f == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [63:0] mag(input logic [31:0] x, input bit sgn);
        return {32'b0, (sgn && x[31]) ? (32'd0 - x) : x};
    endfunction

    // Holds the op until accepted, then pushes its expected result.
    task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] p, input logic [4:0] r, input logic [31:0] expv);
        bit got;
        issue_valid   = 1'b1;
        issue_func    = f;
        issue_opa     = a;
        issue_opb     = b;
        issue_prf_idx = p;
        issue_rob_idx = r;
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clock);
            if (issue_ready) got = 1'b1;
            else begin @(posedge clock); #1; end
        end
        chk("issue_accept", 64'(got), 64'd1);
        if (got) begin
            chk("mul_start", 64'(mul_start), 64'd1);
            chk("mcand", mul_mcand, mag(a, f != 2'd3));
            chk("mplier", mul_mplier, mag(b, f < 2'd2));
            sb_q.push_back('{value: expv, prf: p, rob: r});
        end
        @(posedge clock); #1;
        issue_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 100 && sb_q.size() != 0; n++) @(negedge clock);
        chk("drain", 64'(sb_q.size()), 64'd0);
        @(posedge clock); #1;
    endtask

    // Output monitor: in-order compare against the scoreboard
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            chk("credit_bound", 64'(sb_q.size() <= OUT_DEPTH), 64'd1);
            if (cdb_valid && cdb_grant) begin
                chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("cdb_value", 64'(cdb_value), 64'(e.value));
                    chk("cdb_prf", 64'(cdb_prf_idx), 64'(e.prf));
                    chk("cdb_rob", 64'(cdb_rob_idx), 64'(e.rob));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        logic [1:0]  rf;
        logic [31:0] ra, rb;

        // Reset state
        repeat (2) @(posedge clock);
        #1 issue_valid = 1'b1;
        @(negedge clock);
        chk("rst_mul_start", 64'(mul_start), 64'd0);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rst_err_desync", 64'(err_desync), 64'd0);
        @(posedge clock); #1;
        issue_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", 64'(issue_ready), 64'd1);
        chk("post_rst_cdb_valid", 64'(cdb_valid), 64'd0);
        @(posedge clock); #1;

        // Latency: issued in cycle 0, visible in cycle 9
        issue(2'd0, 32'd3, 32'hFFFFFFFB, 6'd17, 5'd9, 32'hFFFFFFF1);
        repeat (8) @(negedge clock);
        chk("lat_cycle8_idle", 64'(cdb_valid), 64'd0);
        @(negedge clock);
        chk("lat_cycle9_valid", 64'(cdb_valid), 64'd1);
        @(posedge clock); #1;
        wait_drain();

        // Sign-correction corner cases
        issue(2'd1, 32'h80000000, 32'h80000000, 6'd1, 5'd1, 32'h40000000);
        issue(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd2, 5'd2, 32'hFFFFFFFE);
        issue(2'd2, 32'hFFFFFFFF, 32'd2,        6'd3, 5'd3, 32'hFFFFFFFF);
        issue(2'd0, 32'h80000000, 32'hFFFFFFFF, 6'd4, 5'd4, 32'h80000000);
        wait_drain();

        // Backpressure: four ops with no grant exhaust the credits
        cdb_grant = 1'b0;
        issue(2'd0, 32'd7,  32'd9,        6'd10, 5'd10, ref_mul(2'd0, 32'd7, 32'd9));
        issue(2'd1, 32'hFFFF0000, 32'd5,  6'd11, 5'd11, ref_mul(2'd1, 32'hFFFF0000, 32'd5));
        issue(2'd2, 32'h12345678, 32'hDEADBEEF, 6'd12, 5'd12, ref_mul(2'd2, 32'h12345678, 32'hDEADBEEF));
        issue(2'd3, 32'hCAFEF00D, 32'h0BADF00D, 6'd13, 5'd13, ref_mul(2'd3, 32'hCAFEF00D, 32'h0BADF00D));
        @(negedge clock);
        chk("bp_ready_low", 64'(issue_ready), 64'd0);
        repeat (12) @(negedge clock);
        chk("bp_ready_still_low", 64'(issue_ready), 64'd0);
        chk("bp_cdb_valid", 64'(cdb_valid), 64'd1);
        @(posedge clock); #1;
        cdb_grant = 1'b1;
        @(negedge clock);
        chk("bp_ready_pop_cycle", 64'(issue_ready), 64'd0);
        @(negedge clock);
        chk("bp_ready_after_pop", 64'(issue_ready), 64'd1);
        @(posedge clock); #1;
        wait_drain();

        // FIFO wrap with a toggling grant
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    rf = 2'($urandom_range(3, 0));
                    ra = $urandom;
                    rb = $urandom;
                    issue(rf, ra, rb, 6'(20 + i), 5'(i), ref_mul(rf, ra, rb));
                end
            end
            begin
                repeat (40) begin
                    @(posedge clock); #1;
                    cdb_grant = ~cdb_grant;
                end
            end
        join
        cdb_grant = 1'b1;
        wait_drain();
        chk("wrap_err_desync", 64'(err_desync), 64'd0);

        // Reset with three ops in flight discards them
        issue(2'd0, 32'd11, 32'd12, 6'd40, 5'd20, ref_mul(2'd0, 32'd11, 32'd12));
        issue(2'd1, 32'd13, 32'd14, 6'd41, 5'd21, ref_mul(2'd1, 32'd13, 32'd14));
        issue(2'd3, 32'd15, 32'd16, 6'd42, 5'd22, ref_mul(2'd3, 32'd15, 32'd16));
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        issue_valid = 1'b1;
        @(negedge clock);
        chk("midrst_mul_start", 64'(mul_start), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        issue_valid = 1'b0;
        sb_q.delete();
        @(negedge clock);
        chk("midrst_ready", 64'(issue_ready), 64'd1);
        hi = 0;
        repeat (20) begin
            @(negedge clock);
            if (cdb_valid) hi++;
        end
        chk("midrst_no_cdb", 64'(hi), 64'd0);
        chk("midrst_err_desync", 64'(err_desync), 64'd0);
        @(posedge clock); #1;

`ifdef MUL_SQUASH_EN
        // Squash with one queued result and two ops in flight
        cdb_grant = 1'b0;
        issue(2'd0, 32'd21, 32'd22, 6'd50, 5'd25, ref_mul(2'd0, 32'd21, 32'd22));
        for (int n = 0; n < 30 && !cdb_valid; n++) @(negedge clock);
        chk("sq_first_queued", 64'(cdb_valid), 64'd1);
        @(posedge clock); #1;
        issue(2'd1, 32'd23, 32'd24, 6'd51, 5'd26, ref_mul(2'd1, 32'd23, 32'd24));
        issue(2'd2, 32'd25, 32'd26, 6'd52, 5'd27, ref_mul(2'd2, 32'd25, 32'd26));
        squash = 1'b1;
        @(negedge clock);
        chk("sq_ready_low", 64'(issue_ready), 64'd0);
        @(posedge clock); #1;
        squash = 1'b0;
        sb_q.delete();
        @(negedge clock);
        chk("sq_cdb_cleared", 64'(cdb_valid), 64'd0);
        chk("sq_credit_restored", 64'(issue_ready), 64'd1);
        hi = 0;
        repeat (20) begin
            @(negedge clock);
            if (cdb_valid) hi++;
        end
        chk("sq_no_push", 64'(hi), 64'd0);
        chk("sq_err_desync", 64'(err_desync), 64'd0);
        cdb_grant = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
